// File: rtl/thread_register_file_if.sv
// Operand/write-back bus between a thread's decoder/ALU/LSU and its register file.
// The master drives decode, state and result signals; the slave returns operands.
interface thread_register_file_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 enable;
  logic [7:0]           block_id;
  logic [2:0]           core_state;
  logic [3:0]           decoded_rd_address;
  logic [3:0]           decoded_rs_address;
  logic [3:0]           decoded_rt_address;
  logic                 decoded_reg_write_enable;
  logic [1:0]           decoded_reg_input_mux;
  logic [DATA_BITS-1:0] decoded_immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic [DATA_BITS-1:0] lsu_out;
  logic [DATA_BITS-1:0] rs;
  logic [DATA_BITS-1:0] rt;
  logic                 ro_write_err;

  modport master (
    output enable, block_id, core_state, decoded_rd_address, decoded_rs_address,
           decoded_rt_address, decoded_reg_write_enable, decoded_reg_input_mux,
           decoded_immediate, alu_out, lsu_out,
    input  rs, rt, ro_write_err
  );

  modport slave (
    input  enable, block_id, core_state, decoded_rd_address, decoded_rs_address,
           decoded_rt_address, decoded_reg_write_enable, decoded_reg_input_mux,
           decoded_immediate, alu_out, lsu_out,
    output rs, rt, ro_write_err
  );
endinterface

// File: rtl/thread_register_file.sv
// Per-thread 16-entry register file: operands latched in REQUEST, write-back in UPDATE.
// Optional macro REGFILE_ZERO_R0_EN hardwires R0 to zero.
module thread_register_file #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_ID         = 0,
  parameter int unsigned DATA_BITS         = 8
) (
  input logic                   clk,
  input logic                   reset,
  thread_register_file_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StFetch   = 3'b001,
    StDecode  = 3'b010,
    StRequest = 3'b011,
    StWait    = 3'b100,
    StExecute = 3'b101,
    StUpdate  = 3'b110,
    StDone    = 3'b111
  } core_state_e;

  localparam logic [3:0] LastGprAddr = 4'd12;

  logic [DATA_BITS-1:0] regs_q [16];
  logic [DATA_BITS-1:0] regs_d [16];
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_valid;

  always_comb begin
    wr_data      = '0;
    wr_src_valid = 1'b1;
    case (bus.decoded_reg_input_mux)
      2'b00:   wr_data = bus.alu_out;
      2'b01:   wr_data = bus.lsu_out;
      2'b10:   wr_data = bus.decoded_immediate;
      default: wr_src_valid = 1'b0;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    err_d  = err_q;
    if (bus.enable) begin
      // R13 tracks block_id every enabled cycle, so reads see last cycle's value.
      regs_d[13] = DATA_BITS'(bus.block_id);
      if (bus.core_state == StRequest) begin
        rs_d = regs_q[bus.decoded_rs_address];
        rt_d = regs_q[bus.decoded_rt_address];
`ifdef REGFILE_ZERO_R0_EN
        if (bus.decoded_rs_address == 4'd0) rs_d = '0;
        if (bus.decoded_rt_address == 4'd0) rt_d = '0;
`endif
      end
      if (bus.core_state == StUpdate && bus.decoded_reg_write_enable) begin
        if (bus.decoded_rd_address > LastGprAddr) begin
          err_d = 1'b1;
        end else if (wr_src_valid) begin
`ifdef REGFILE_ZERO_R0_EN
          if (bus.decoded_rd_address != 4'd0) regs_d[bus.decoded_rd_address] = wr_data;
`else
          regs_d[bus.decoded_rd_address] = wr_data;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 14; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[14] <= DATA_BITS'(THREADS_PER_BLOCK);
      regs_q[15] <= DATA_BITS'(THREAD_ID);
      rs_q       <= '0;
      rt_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      err_q  <= err_d;
    end
  end

  assign bus.rs           = rs_q;
  assign bus.rt           = rt_q;
  assign bus.ro_write_err = err_q;

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file with THREADS_PER_BLOCK=4, THREAD_ID=2.
// Build with or without REGFILE_ZERO_R0_EN; the R0 expectation follows the macro.
module tb_thread_register_file;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  thread_register_file_if #(.DATA_BITS(8)) bus ();

  thread_register_file #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID        (2),
    .DATA_BITS        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.core_state = 3'b000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // REQUEST one cycle; returns in WAIT with operands valid.
  task automatic do_request(input logic [3:0] rs_a, input logic [3:0] rt_a);
    bus.decoded_rs_address = rs_a;
    bus.decoded_rt_address = rt_a;
    bus.core_state         = 3'b011;
    tick();
    bus.core_state = 3'b100;
  endtask

  task automatic do_update(input logic [3:0] rd, input logic we, input logic [1:0] mux,
                           input logic [7:0] alu, input logic [7:0] lsu, input logic [7:0] imm);
    bus.decoded_rd_address       = rd;
    bus.decoded_reg_write_enable = we;
    bus.decoded_reg_input_mux    = mux;
    bus.alu_out                  = alu;
    bus.lsu_out                  = lsu;
    bus.decoded_immediate        = imm;
    bus.core_state               = 3'b110;
    tick();
    bus.decoded_reg_write_enable = 1'b0;
    bus.core_state               = 3'b111;
    tick();
  endtask

  // FETCH..DONE with a REQUEST of (rs_a, rt_a) and a write of alu to rd.
  task automatic full_instr(input logic [3:0] rs_a, input logic [3:0] rt_a,
                            input logic [3:0] rd, input logic [7:0] alu);
    bus.core_state = 3'b001;
    tick();
    bus.core_state = 3'b010;
    tick();
    do_request(rs_a, rt_a);
    tick();
    bus.core_state = 3'b101;
    tick();
    do_update(rd, 1'b1, 2'b00, alu, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rs !== 8'h00) begin errors++; $display("FAIL reset_rs got %h want 00", bus.rs); end
    checks++;
    if (bus.rt !== 8'h00) begin errors++; $display("FAIL reset_rt got %h want 00", bus.rt); end
    checks++;
    if (bus.ro_write_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", bus.ro_write_err);
    end
    do_request(4'd14, 4'd15);
    checks++;
    if (bus.rs !== 8'h04) begin errors++; $display("FAIL r14_blockdim got %h want 04", bus.rs); end
    checks++;
    if (bus.rt !== 8'h02) begin errors++; $display("FAIL r15_threadidx got %h want 02", bus.rt); end
    // R0..R13 all zero after reset (block_id held at 0).
    for (int a = 0; a < 14; a += 2) begin
      do_request(4'(a), 4'(a + 1));
      checks++;
      if (bus.rs !== 8'h00) begin
        errors++; $display("FAIL reset_r%0d got %h want 00", a, bus.rs);
      end
      checks++;
      if (bus.rt !== 8'h00) begin
        errors++; $display("FAIL reset_r%0d got %h want 00", a + 1, bus.rt);
      end
    end
  endtask

  task automatic test_write_sources();
    do_update(4'd3, 1'b1, 2'b00, 8'h5A, 8'hC3, 8'h3C);
    do_update(4'd4, 1'b1, 2'b01, 8'hC3, 8'h11, 8'h3C);
    do_update(4'd5, 1'b1, 2'b10, 8'hC3, 8'hC3, 8'h7F);
    do_update(4'd7, 1'b1, 2'b11, 8'hEE, 8'hEE, 8'hEE);
    do_update(4'd8, 1'b0, 2'b00, 8'hDD, 8'hDD, 8'hDD);
    do_request(4'd3, 4'd4);
    checks++;
    if (bus.rs !== 8'h5A) begin errors++; $display("FAIL alu_wr got %h want 5a", bus.rs); end
    checks++;
    if (bus.rt !== 8'h11) begin errors++; $display("FAIL lsu_wr got %h want 11", bus.rt); end
    do_request(4'd5, 4'd7);
    checks++;
    if (bus.rs !== 8'h7F) begin errors++; $display("FAIL imm_wr got %h want 7f", bus.rs); end
    checks++;
    if (bus.rt !== 8'h00) begin errors++; $display("FAIL mux11_nowr got %h want 00", bus.rt); end
    do_request(4'd8, 4'd3);
    checks++;
    if (bus.rs !== 8'h00) begin errors++; $display("FAIL we0_nowr got %h want 00", bus.rs); end
    do_request(4'd3, 4'd3);
    checks++;
    if (bus.rs !== 8'h5A || bus.rt !== 8'h5A) begin
      errors++; $display("FAIL same_addr got rs=%h rt=%h want 5a/5a", bus.rs, bus.rt);
    end
    checks++;
    if (bus.ro_write_err !== 1'b0) begin
      errors++; $display("FAIL mux11_noerr got %b want 0", bus.ro_write_err);
    end
  endtask

  task automatic test_block_id_ro();
    bus.block_id = 8'd9;
    idle(2);
    do_request(4'd13, 4'd14);
    checks++;
    if (bus.rs !== 8'd9) begin errors++; $display("FAIL r13_block got %h want 09", bus.rs); end
    do_update(4'd13, 1'b1, 2'b00, 8'h44, 8'h44, 8'h44);
    do_update(4'd14, 1'b1, 2'b10, 8'h44, 8'h44, 8'h44);
    do_request(4'd13, 4'd14);
    checks++;
    if (bus.rs !== 8'd9) begin errors++; $display("FAIL r13_ro got %h want 09", bus.rs); end
    checks++;
    if (bus.rt !== 8'h04) begin errors++; $display("FAIL r14_ro got %h want 04", bus.rt); end
    checks++;
    if (bus.ro_write_err !== 1'b1) begin
      errors++; $display("FAIL ro_err_set got %b want 1", bus.ro_write_err);
    end
    idle(10);
    checks++;
    if (bus.ro_write_err !== 1'b1) begin
      errors++; $display("FAIL ro_err_sticky got %b want 1", bus.ro_write_err);
    end
    bus.block_id = 8'd0;
  endtask

  task automatic test_enable();
    do_reset();
    do_update(4'd3, 1'b1, 2'b10, 8'h00, 8'h00, 8'h12);
    do_request(4'd3, 4'd14);
    bus.enable   = 1'b0;
    bus.block_id = 8'h55;
    full_instr(4'd2, 4'd15, 4'd2, 8'hFF);
    do_update(4'd13, 1'b1, 2'b00, 8'hFF, 8'h00, 8'h00);
    checks++;
    if (bus.rs !== 8'h12 || bus.rt !== 8'h04) begin
      errors++; $display("FAIL en0_hold got rs=%h rt=%h want 12/04", bus.rs, bus.rt);
    end
    checks++;
    if (bus.ro_write_err !== 1'b0) begin
      errors++; $display("FAIL en0_noerr got %b want 0", bus.ro_write_err);
    end
    bus.enable = 1'b1;
    do_request(4'd2, 4'd3);
    checks++;
    if (bus.rs !== 8'h00) begin errors++; $display("FAIL en0_nowr got %h want 00", bus.rs); end
    full_instr(4'd3, 4'd3, 4'd2, 8'hFF);
    do_request(4'd2, 4'd13);
    checks++;
    if (bus.rs !== 8'hFF) begin errors++; $display("FAIL en1_wr got %h want ff", bus.rs); end
    checks++;
    if (bus.rt !== 8'h55) begin errors++; $display("FAIL en1_r13 got %h want 55", bus.rt); end
    bus.block_id = 8'd0;
  endtask

  task automatic test_reset_in_update();
    do_update(4'd15, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    do_request(4'd14, 4'd15);
    bus.decoded_rd_address       = 4'd6;
    bus.decoded_reg_write_enable = 1'b1;
    bus.decoded_reg_input_mux    = 2'b10;
    bus.decoded_immediate        = 8'h33;
    bus.core_state               = 3'b110;
    reset                        = 1'b1;
    tick();
    reset                        = 1'b0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.core_state               = 3'b000;
    checks++;
    if (bus.rs !== 8'h00 || bus.rt !== 8'h00) begin
      errors++; $display("FAIL rst_upd_ops got rs=%h rt=%h want 00/00", bus.rs, bus.rt);
    end
    checks++;
    if (bus.ro_write_err !== 1'b0) begin
      errors++; $display("FAIL rst_upd_err got %b want 0", bus.ro_write_err);
    end
    do_request(4'd6, 4'd14);
    checks++;
    if (bus.rs !== 8'h00) begin errors++; $display("FAIL rst_upd_r6 got %h want 00", bus.rs); end
    checks++;
    if (bus.rt !== 8'h04) begin errors++; $display("FAIL rst_upd_r14 got %h want 04", bus.rt); end
  endtask

  task automatic test_r0();
    logic [7:0] exp_r0;
`ifdef REGFILE_ZERO_R0_EN
    exp_r0 = 8'h00;
`else
    exp_r0 = 8'hAA;
`endif
    do_update(4'd0, 1'b1, 2'b10, 8'h00, 8'h00, 8'hAA);
    do_request(4'd0, 4'd0);
    checks++;
    if (bus.rs !== exp_r0 || bus.rt !== exp_r0) begin
      errors++;
      $display("FAIL r0_write got rs=%h rt=%h want %h", bus.rs, bus.rt, exp_r0);
    end
    checks++;
    if (bus.ro_write_err !== 1'b0) begin
      errors++; $display("FAIL r0_noerr got %b want 0", bus.ro_write_err);
    end
  endtask

  initial begin
    checks                       = 0;
    errors                       = 0;
    reset                        = 1'b1;
    bus.enable                   = 1'b1;
    bus.block_id                 = 8'd0;
    bus.core_state               = 3'b000;
    bus.decoded_rd_address       = 4'd0;
    bus.decoded_rs_address       = 4'd0;
    bus.decoded_rt_address       = 4'd0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.decoded_reg_input_mux    = 2'b00;
    bus.decoded_immediate        = 8'h00;
    bus.alu_out                  = 8'h00;
    bus.lsu_out                  = 8'h00;
    #2;
    test_reset();
    test_write_sources();
    test_block_id_ro();
    test_enable();
    test_reset_in_update();
    test_r0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
